// File: rtl/ultra_pkg.sv
// Shared constants and the conversion FSM encoding for the ultrasonic ranging filter.
// Defaults assume a 50 MHz clock: 58 us round trip per centimetre.
package ultra_pkg;

    localparam int unsigned CYC_PER_CM_DEF = 2900;
    localparam int unsigned MIN_CYC_DEF    = 5800;
    localparam int unsigned MAX_CYC_DEF    = 870000;

    localparam int unsigned CYC_W        = 20;
    localparam int unsigned SUM_W        = CYC_W + 2;
    localparam int unsigned DIST_W       = 9;
    localparam int unsigned DIST_MAX     = 511;
    localparam int unsigned WIN_DEPTH    = 4;
    localparam int unsigned REJECT_LIMIT = 3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DIVIDE = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

endpackage

// File: rtl/ult_divider.sv
// Restoring shift-subtract divider by a constant: one quotient bit per clock,
// the first bit on the start edge, done pulses exactly CYC_W cycles after start.
module ult_divider
    import ultra_pkg::*;
#(
    parameter int unsigned DIVISOR = CYC_PER_CM_DEF
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start,
    input  logic [CYC_W-1:0] dividend,
    output logic             done,
    output logic [CYC_W-1:0] quotient
);

    localparam int unsigned        CNT_W = $clog2(CYC_W + 1);
    localparam logic [CYC_W:0]     DIV_V = (CYC_W + 1)'(DIVISOR);
    localparam logic [CNT_W-1:0]   LAST  = CNT_W'(CYC_W - 1);

    logic [CYC_W:0]   rem;
    logic [CYC_W-1:0] dvd;
    logic [CNT_W-1:0] cnt;
    logic             running;

    logic [CYC_W:0]   shifted;
    logic [CYC_W:0]   step_rem;
    logic             step_bit;

    // The partial remainder is always below the divisor, so dropping its MSB on shift is safe.
    always_comb begin
        shifted  = start ? {{CYC_W{1'b0}}, dividend[CYC_W-1]}
                         : {rem[CYC_W-1:0], dvd[CYC_W-1]};
        step_bit = (shifted >= DIV_V);
        step_rem = step_bit ? (shifted - DIV_V) : shifted;
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            rem      <= '0;
            dvd      <= '0;
            cnt      <= '0;
            running  <= 1'b0;
            done     <= 1'b0;
            quotient <= '0;
        end else begin
            done <= 1'b0;
            if (start) begin
                rem      <= step_rem;
                dvd      <= {dividend[CYC_W-2:0], 1'b0};
                quotient <= {{(CYC_W-1){1'b0}}, step_bit};
                cnt      <= CNT_W'(1);
                running  <= 1'b1;
            end else if (running) begin
                rem      <= step_rem;
                dvd      <= {dvd[CYC_W-2:0], 1'b0};
                quotient <= {quotient[CYC_W-2:0], step_bit};
                cnt      <= cnt + 1'b1;
                if (cnt == LAST) begin
                    running <= 1'b0;
                    done    <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/echo_distance_filter.sv
// Range-gates raw echo counts, averages the last four good samples and converts
// the mean to centimetres; repeated bad echoes flush the averaging window.
module echo_distance_filter
    import ultra_pkg::*;
#(
    parameter int unsigned CYC_PER_CM = CYC_PER_CM_DEF,
    parameter int unsigned MIN_CYC    = MIN_CYC_DEF,
    parameter int unsigned MAX_CYC    = MAX_CYC_DEF
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [CYC_W-1:0]  cycles_in,
    input  logic              cycles_valid,
    output logic [DIST_W-1:0] dist_cm,
    output logic              dist_valid,
    output logic              out_of_range,
    output logic              overrun,
    output logic              busy
);

    localparam int unsigned       PTR_W     = $clog2(WIN_DEPTH);
    localparam int unsigned       FILL_W    = $clog2(WIN_DEPTH + 1);
    localparam int unsigned       REJ_W     = $clog2(REJECT_LIMIT);
    localparam logic [CYC_W-1:0]  MIN_V     = CYC_W'(MIN_CYC);
    localparam logic [CYC_W-1:0]  MAX_V     = CYC_W'(MAX_CYC);
    localparam logic [CYC_W-1:0]  SAT_V     = CYC_W'(DIST_MAX);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(WIN_DEPTH);
    localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(WIN_DEPTH - 1);
    localparam logic [REJ_W-1:0]  REJ_LAST  = REJ_W'(REJECT_LIMIT - 1);

    logic [CYC_W-1:0]  window [WIN_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [FILL_W-1:0] fill;
    logic [REJ_W-1:0]  rej_cnt;
    state_t            state, next_state;

    logic              in_range, accept, reject, start_div;
    logic [SUM_W-1:0]  sum;
    logic [CYC_W-1:0]  mean;
    logic              div_done;
    logic [CYC_W-1:0]  quotient;

    // Strobes arriving outside IDLE are dropped; they only raise overrun.
    assign in_range  = (cycles_in >= MIN_V) && (cycles_in <= MAX_V);
    assign accept    = cycles_valid && (state == ST_IDLE) && in_range;
    assign reject    = cycles_valid && (state == ST_IDLE) && !in_range;
    assign start_div = accept && (fill >= FILL_LAST);

    // The mean must include the sample being written this cycle, so substitute it for its slot.
    always_comb begin
        sum = '0;
        for (int i = 0; i < WIN_DEPTH; i++) begin
            sum = sum + SUM_W'((wr_ptr == PTR_W'(i)) ? cycles_in : window[i]);
        end
        mean = sum[CYC_W+1:2];
    end

    // NOTE: the window is cleared on reset because a partially refilled window never
    // reaches the divider, yet a defined power-up image keeps simulation and silicon equal.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            for (int i = 0; i < WIN_DEPTH; i++) window[i] <= '0;
            wr_ptr  <= '0;
            fill    <= '0;
            rej_cnt <= '0;
        end else if (accept) begin
            window[wr_ptr] <= cycles_in;
            wr_ptr         <= wr_ptr + 1'b1;
            rej_cnt        <= '0;
            if (fill != FILL_FULL) fill <= fill + 1'b1;
        end else if (reject) begin
            if (rej_cnt == REJ_LAST) begin
                fill    <= '0;
                wr_ptr  <= '0;
                rej_cnt <= '0;
            end else begin
                rej_cnt <= rej_cnt + 1'b1;
            end
        end
    end

    ult_divider #(
        .DIVISOR (CYC_PER_CM)
    ) u_divider (
        .clock    (clock),
        .reset_n  (reset_n),
        .start    (start_div),
        .dividend (mean),
        .done     (div_done),
        .quotient (quotient)
    );

    always_ff @(posedge clock) begin
        if (!reset_n) state <= ST_IDLE;
        else          state <= next_state;
    end

    // NOTE: every variable gets a default before the case so no path can infer a latch.
    always_comb begin
        next_state = state;
        unique case (state)
            ST_IDLE:   if (start_div) next_state = ST_DIVIDE;
            ST_DIVIDE: if (div_done)  next_state = ST_DONE;
            ST_DONE:   next_state = ST_IDLE;
            default:   next_state = ST_IDLE;
        endcase
    end

    // Outputs are registered from next-cycle values so no input reaches a pin combinationally.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            dist_cm      <= '0;
            dist_valid   <= 1'b0;
            out_of_range <= 1'b0;
            overrun      <= 1'b0;
            busy         <= 1'b0;
        end else begin
            dist_valid <= 1'b0;
            overrun    <= cycles_valid && (state != ST_IDLE);
            busy       <= (next_state != ST_IDLE);
            if (accept) out_of_range <= 1'b0;
            if (reject) out_of_range <= 1'b1;
            if (state == ST_DIVIDE && div_done) begin
                dist_cm    <= (quotient > SAT_V) ? SAT_V[DIST_W-1:0] : quotient[DIST_W-1:0];
                dist_valid <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_echo_distance_filter.sv
// Cycle-by-cycle comparison of echo_distance_filter against a queue-based model
// of the ranging rules, with directed scenarios followed by random traffic.
module tb_echo_distance_filter;

    localparam int CPC    = 2900;
    localparam int LO     = 5800;
    localparam int HI     = 870000;
    localparam int CONV_T = 21;

    logic        clock;
    logic        reset_n;
    logic [19:0] cycles_in;
    logic        cycles_valid;
    logic [8:0]  dist_cm;
    logic        dist_valid;
    logic        out_of_range;
    logic        overrun;
    logic        busy;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // reference model state
    int   win_q[$];
    int   rejects;
    int   conv_t;
    int   conv_res;
    int   e_dist;
    logic e_valid, e_oor, e_ovr, e_busy;

    echo_distance_filter dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .cycles_in    (cycles_in),
        .cycles_valid (cycles_valid),
        .dist_cm      (dist_cm),
        .dist_valid   (dist_valid),
        .out_of_range (out_of_range),
        .overrun      (overrun),
        .busy         (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
        checks++;
        if (obs !== want) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0d expected %0d", tag, cyc, obs, want);
        end
    endtask

    // Conversion timeline counted from the accepted strobe: result visible 21 cycles later,
    // machine free again one cycle after that.
    task automatic model_step(input logic v, input int c, input logic rn);
        int sum;
        int q;
        if (!rn) begin
            win_q.delete();
            rejects = 0; conv_t = 0;
            e_dist = 0; e_valid = 0; e_oor = 0; e_ovr = 0; e_busy = 0;
            return;
        end
        e_valid = 0;
        e_ovr   = 0;
        if (conv_t == 0) begin
            if (v) begin
                if (c >= LO && c <= HI) begin
                    win_q.push_back(c);
                    if (win_q.size() > 4) void'(win_q.pop_front());
                    rejects = 0;
                    e_oor   = 0;
                    if (win_q.size() == 4) begin
                        sum = 0;
                        foreach (win_q[i]) sum += win_q[i];
                        q = (sum / 4) / CPC;
                        conv_res = (q > 511) ? 511 : q;
                        conv_t   = 1;
                    end
                end else begin
                    e_oor = 1;
                    rejects++;
                    if (rejects == 3) begin
                        win_q.delete();
                        rejects = 0;
                    end
                end
            end
        end else begin
            if (v) e_ovr = 1;
            conv_t++;
            if (conv_t == CONV_T) begin
                e_valid = 1;
                e_dist  = conv_res;
            end
            if (conv_t == CONV_T + 1) conv_t = 0;
        end
        e_busy = (conv_t != 0);
    endtask

    task automatic tick(input logic v, input int c, input logic rn);
        cycles_valid = v;
        cycles_in    = 20'(c);
        reset_n      = rn;
        @(posedge clock);
        model_step(v, c, rn);
        cyc++;
        @(negedge clock);
        check("dist_valid",   32'(dist_valid),   32'(e_valid));
        check("dist_cm",      32'(dist_cm),      32'(e_dist));
        check("out_of_range", 32'(out_of_range), 32'(e_oor));
        check("overrun",      32'(overrun),      32'(e_ovr));
        check("busy",         32'(busy),         32'(e_busy));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 0, 1'b1);
    endtask

    task automatic strobe(input int c);
        tick(1'b1, c, 1'b1);
    endtask

    function automatic int rand_sample();
        case ($urandom_range(0, 11))
            0:       return LO;
            1:       return HI;
            2:       return LO - 1;
            3:       return HI + 1;
            4:       return int'($urandom_range(0, LO - 1));
            5:       return int'($urandom_range(HI + 1, 1048575));
            default: return int'($urandom_range(LO, HI));
        endcase
    endfunction

    initial begin
        cycles_valid = 1'b0;
        cycles_in    = '0;
        reset_n      = 1'b0;

        // reset held with strobes present
        tick(1'b1, 29000, 1'b0);
        tick(1'b1, 29000, 1'b0);
        idle(3);

        // four equal samples give one result of 10 cm
        for (int i = 0; i < 4; i++) begin
            strobe(29000);
            idle(29);
        end
        check("dist_10cm", 32'(dist_cm), 32'd10);

        // heavier window entries shift the mean
        strobe(58000);
        idle(24);
        check("dist_12cm", 32'(dist_cm), 32'd12);
        strobe(58000);
        idle(24);
        check("dist_15cm", 32'(dist_cm), 32'd15);

        // bounds just outside, then exactly on the upper bound
        strobe(5799);
        idle(2);
        strobe(870001);
        idle(2);
        check("oor_set", 32'(out_of_range), 32'd1);
        strobe(870000);
        idle(24);
        check("oor_clear", 32'(out_of_range), 32'd0);

        // three rejects flush; refill needs four fresh samples
        for (int i = 0; i < 3; i++) begin
            strobe(1000);
            idle(2);
        end
        for (int i = 0; i < 4; i++) begin
            strobe(29000);
            idle(24);
        end
        check("refill_10cm", 32'(dist_cm), 32'd10);

        // strobe during conversion is dropped, then reset aborts a conversion
        strobe(29000);
        idle(4);
        strobe(870000);
        idle(25);
        check("overrun_result", 32'(dist_cm), 32'd10);
        strobe(29000);
        idle(9);
        tick(1'b0, 0, 1'b0);
        idle(30);
        check("abort_dist", 32'(dist_cm), 32'd0);

        // random traffic with occasional resets
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 499) == 0)
                tick(1'b0, 0, 1'b0);
            else if ($urandom_range(0, 3) == 0)
                strobe(rand_sample());
            else
                idle(1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
